// File: rtl/ucie_pkg.sv
// Shared types and default sizing for the UCIe stack scheduler.
package ucie_pkg;

    localparam int unsigned NUM_STACKS_DEFAULT = 4;
    localparam int unsigned CREDIT_W_DEFAULT   = 8;
    localparam int unsigned WEIGHT_W_DEFAULT   = 4;
    localparam int unsigned RET_COUNT_W        = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant  = 2'd1,
        StRefill = 2'd2
    } sched_state_t;

endpackage

// File: rtl/ucie_rr_pick.sv
// Rotating first-set search: lowest set bit of req at or after start, wrapping.
module ucie_rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        idx   = '0;
        found = |req;
        // Walk downwards so the candidate closest to start is written last.
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (req[(int'(start) + k) % int'(N)]) begin
                idx = IDX_W'((int'(start) + k) % int'(N));
            end
        end
    end

endmodule

// File: rtl/ucie_stack_wrr_scheduler.sv
// Weighted round-robin flit scheduler across protocol stacks with per-stack
// link credits and per-round budgets.
module ucie_stack_wrr_scheduler
    import ucie_pkg::*;
#(
    parameter int unsigned NUM_STACKS = NUM_STACKS_DEFAULT,
    parameter int unsigned CREDIT_W   = CREDIT_W_DEFAULT,
    parameter int unsigned WEIGHT_W   = WEIGHT_W_DEFAULT,
    localparam int unsigned IDX_W     = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_STACKS-1:0]          cfg_enable,
    input  logic [WEIGHT_W*NUM_STACKS-1:0] cfg_weight,
    input  logic [CREDIT_W*NUM_STACKS-1:0] cfg_init_credit,
    input  logic                           cfg_load,
    input  logic [NUM_STACKS-1:0]          req_valid,
    output logic [NUM_STACKS-1:0]          gnt,
    output logic                           gnt_valid,
    output logic [IDX_W-1:0]               gnt_stack_id,
    input  logic                           gnt_accept,
    input  logic                           credit_ret_valid,
    input  logic [IDX_W-1:0]               credit_ret_stack,
    input  logic [RET_COUNT_W-1:0]         credit_ret_count,
    output logic [CREDIT_W*NUM_STACKS-1:0] credit_avail,
    output logic                           credit_ovf_err,
    output logic [1:0]                     sched_state
);

    localparam int unsigned SUM_W = CREDIT_W + RET_COUNT_W + 1;
    localparam logic [SUM_W-1:0] CREDIT_MAX = {{(SUM_W - CREDIT_W){1'b0}}, {CREDIT_W{1'b1}}};

    sched_state_t         state_q, state_d;
    logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic                 ovf_q, ovf_d;
    logic [CREDIT_W-1:0]  credit_q [NUM_STACKS];
    logic [CREDIT_W-1:0]  credit_d [NUM_STACKS];
    logic [WEIGHT_W-1:0]  budget_q [NUM_STACKS];
    logic [WEIGHT_W-1:0]  budget_d [NUM_STACKS];
    logic [SUM_W-1:0]     sum      [NUM_STACKS];
    logic [NUM_STACKS-1:0] elig, sel;
    logic [IDX_W-1:0]     start_idx, pick_idx;
    logic                 pick_found;
    logic                 consume;

    function automatic logic [WEIGHT_W-1:0] reload_budget(input logic [WEIGHT_W-1:0] w);
        return (w == '0) ? WEIGHT_W'(1) : w;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_STACKS; i++) begin
            elig[i] = cfg_enable[i] & req_valid[i] & (credit_q[i] != '0);
            sel[i]  = elig[i] & (budget_q[i] != '0);
        end
    end

    assign start_idx = (last_q == IDX_W'(NUM_STACKS - 1)) ? '0 : last_q + IDX_W'(1);
    // An accept only counts while the granted stack is still eligible.
    assign consume   = (state_q == StGrant) && gnt_accept && elig[gnt_idx_q] && !cfg_load;

    ucie_rr_pick #(
        .N     (NUM_STACKS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (sel),
        .start (start_idx),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < NUM_STACKS; i++) begin
            credit_d[i] = credit_q[i];
            budget_d[i] = budget_q[i];
            sum[i]      = SUM_W'(credit_q[i]);
            if (cfg_load) begin
                credit_d[i] = cfg_init_credit[i*CREDIT_W +: CREDIT_W];
                budget_d[i] = reload_budget(cfg_weight[i*WEIGHT_W +: WEIGHT_W]);
            end else begin
                if (state_q == StRefill) begin
                    budget_d[i] = reload_budget(cfg_weight[i*WEIGHT_W +: WEIGHT_W]);
                end
                if (credit_ret_valid && credit_ret_stack == IDX_W'(i)) begin
                    sum[i] = sum[i] + SUM_W'(credit_ret_count);
                end
                if (consume && gnt_idx_q == IDX_W'(i)) begin
                    sum[i]      = sum[i] - SUM_W'(1);
                    budget_d[i] = budget_q[i] - WEIGHT_W'(1);
                end
                if (sum[i] > CREDIT_MAX) begin
                    credit_d[i] = '1;
                    ovf_d       = 1'b1;
                end else begin
                    credit_d[i] = sum[i][CREDIT_W-1:0];
                end
            end
        end
        if (cfg_load) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        last_d    = last_q;
        if (cfg_load) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        gnt_idx_d = pick_idx;
                        state_d   = StGrant;
                    end else if (|elig) begin
                        state_d = StRefill;
                    end
                end
                StGrant: begin
                    if (!elig[gnt_idx_q]) begin
                        state_d = StIdle;
                    end else if (consume) begin
                        last_d = gnt_idx_q;
                        // Hold the same stack without a bubble while it still qualifies.
                        if (credit_d[gnt_idx_q] == '0 || budget_d[gnt_idx_q] == '0) begin
                            state_d = StIdle;
                        end
                    end
                end
                StRefill: state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_idx_q <= '0;
            last_q    <= IDX_W'(NUM_STACKS - 1);
            ovf_q     <= 1'b0;
            for (int i = 0; i < NUM_STACKS; i++) begin
                credit_q[i] <= '0;
                budget_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
            for (int i = 0; i < NUM_STACKS; i++) begin
                credit_q[i] <= credit_d[i];
                budget_q[i] <= budget_d[i];
            end
        end
    end

    always_comb begin
        gnt          = '0;
        gnt_valid    = (state_q == StGrant);
        gnt_stack_id = gnt_valid ? gnt_idx_q : '0;
        if (gnt_valid) begin
            gnt[gnt_idx_q] = 1'b1;
        end
        credit_avail = '0;
        for (int i = 0; i < NUM_STACKS; i++) begin
            credit_avail[i*CREDIT_W +: CREDIT_W] = credit_q[i];
        end
    end

    assign credit_ovf_err = ovf_q;
    assign sched_state    = state_q;

endmodule

// File: tb/tb_ucie_stack_wrr_scheduler.sv
// Bench for ucie_stack_wrr_scheduler: directed scenarios plus random traffic,
// all checked every cycle against a behavioural model.
module tb_ucie_stack_wrr_scheduler;

    localparam int NS   = 4;
    localparam int CW   = 8;
    localparam int WW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NS-1:0] cfg_enable = '0;
    logic [WW*NS-1:0] cfg_weight = '0;
    logic [CW*NS-1:0] cfg_init_credit = '0;
    logic          cfg_load = 1'b0;
    logic [NS-1:0] req_valid = '0;
    logic [NS-1:0] gnt;
    logic          gnt_valid;
    logic [1:0]    gnt_stack_id;
    logic          gnt_accept = 1'b0;
    logic          credit_ret_valid = 1'b0;
    logic [1:0]    credit_ret_stack = '0;
    logic [3:0]    credit_ret_count = '0;
    logic [CW*NS-1:0] credit_avail;
    logic          credit_ovf_err;
    logic [1:0]    sched_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ucie_stack_wrr_scheduler #(
        .NUM_STACKS (NS),
        .CREDIT_W   (CW),
        .WEIGHT_W   (WW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_enable       (cfg_enable),
        .cfg_weight       (cfg_weight),
        .cfg_init_credit  (cfg_init_credit),
        .cfg_load         (cfg_load),
        .req_valid        (req_valid),
        .gnt              (gnt),
        .gnt_valid        (gnt_valid),
        .gnt_stack_id     (gnt_stack_id),
        .gnt_accept       (gnt_accept),
        .credit_ret_valid (credit_ret_valid),
        .credit_ret_stack (credit_ret_stack),
        .credit_ret_count (credit_ret_count),
        .credit_avail     (credit_avail),
        .credit_ovf_err   (credit_ovf_err),
        .sched_state      (sched_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_st: 0 idle, 1 granting m_gidx, 2 refill
    int m_cred[NS];
    int m_bud[NS];
    int m_last, m_st, m_gidx;
    bit m_ovf;
    int nc[NS];
    int nb[NS];
    bit el[NS];
    bit sl[NS];
    bit cons, any_el, found;
    int s;

    function automatic int wt(input int i);
        int w;
        w = int'(cfg_weight[i*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                m_cred[i] = 0;
                m_bud[i]  = 0;
            end
            m_last = NS - 1;
            m_ovf  = 1'b0;
            m_st   = 0;
            m_gidx = 0;
        end else if (cfg_load) begin
            for (int i = 0; i < NS; i++) begin
                m_cred[i] = int'(cfg_init_credit[i*CW +: CW]);
                m_bud[i]  = wt(i);
            end
            m_ovf = 1'b0;
            m_st  = 0;
        end else begin
            any_el = 1'b0;
            for (int i = 0; i < NS; i++) begin
                el[i]  = cfg_enable[i] && req_valid[i] && (m_cred[i] > 0);
                sl[i]  = el[i] && (m_bud[i] > 0);
                any_el = any_el | el[i];
            end
            cons = (m_st == 1) && gnt_accept && el[m_gidx];
            for (int i = 0; i < NS; i++) begin
                nc[i] = m_cred[i];
                nb[i] = (m_st == 2) ? wt(i) : m_bud[i];
                if (credit_ret_valid && int'(credit_ret_stack) == i) nc[i] += int'(credit_ret_count);
                if (cons && m_gidx == i) begin
                    nc[i] -= 1;
                    nb[i] -= 1;
                end
                if (nc[i] > CMAX) begin
                    nc[i] = CMAX;
                    m_ovf = 1'b1;
                end
            end
            case (m_st)
                0: begin
                    found = 1'b0;
                    for (int k = 1; k <= NS; k++) begin
                        s = (m_last + k) % NS;
                        if (!found && sl[s]) begin
                            found  = 1'b1;
                            m_gidx = s;
                        end
                    end
                    if (found) m_st = 1;
                    else if (any_el) m_st = 2;
                end
                1: begin
                    if (!el[m_gidx]) m_st = 0;
                    else if (cons) begin
                        m_last = m_gidx;
                        if (nc[m_gidx] == 0 || nb[m_gidx] == 0) m_st = 0;
                    end
                end
                default: m_st = 0;
            endcase
            for (int i = 0; i < NS; i++) begin
                m_cred[i] = nc[i];
                m_bud[i]  = nb[i];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [NS-1:0]    e_gnt;
    logic [CW*NS-1:0] e_cred;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            e_gnt = (m_st == 1) ? (NS'(1) << m_gidx) : '0;
            for (int i = 0; i < NS; i++) e_cred[i*CW +: CW] = CW'(m_cred[i]);
            check("model_gnt", gnt, e_gnt);
            check("model_gnt_valid", gnt_valid, m_st == 1);
            check("model_gnt_stack_id", gnt_stack_id, (m_st == 1) ? m_gidx : 0);
            check("model_credit_avail", credit_avail, e_cred);
            check("model_credit_ovf_err", credit_ovf_err, m_ovf);
            check("model_sched_state", sched_state, m_st);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_load(input logic [WW*NS-1:0] w, input logic [CW*NS-1:0] c);
        cfg_weight      = w;
        cfg_init_credit = c;
        cfg_load        = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic wait_grant(input string name);
        int n;
        n = 0;
        while (!gnt_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_grant_seen"}, gnt_valid, 1'b1);
    endtask

    int trace[$];
    int exp_tr[9] = '{0, 0, 1, 2, 3, 9, 0, 0, 1};
    int cnt, n;

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        check("rst_gnt", gnt, 0);
        check("rst_gnt_valid", gnt_valid, 0);
        check("rst_stack_id", gnt_stack_id, 0);
        check("rst_credit", credit_avail, 0);
        check("rst_ovf", credit_ovf_err, 0);
        check("rst_state", sched_state, 0);

        // No credit yet: requests alone must never grant.
        cfg_enable = 4'hf;
        req_valid  = 4'hf;
        repeat (6) begin
            tick();
            check("no_credit_no_grant", gnt_valid, 0);
        end

        // Weights {2,1,1,1}, credit 8, accept high.
        gnt_accept = 1'b1;
        do_load({4'd1, 4'd1, 4'd1, 4'd2}, {4{8'd8}});
        n = 0;
        while (trace.size() < 9 && n < 40) begin
            if (gnt_valid) trace.push_back(int'(gnt_stack_id));
            else if (sched_state == 2'd2) trace.push_back(9);
            tick();
            n++;
        end
        check("wrr_trace_len", trace.size(), 9);
        for (int i = 0; i < trace.size() && i < 9; i++) check("wrr_order", trace[i], exp_tr[i]);

        // Stack 2 alone with 3 credits.
        do_load(16'h0100, 32'h0003_0000);
        cnt = 0;
        repeat (25) begin
            if (gnt_valid) cnt++;
            tick();
        end
        check("s2_grant_count", cnt, 3);
        check("s2_credit_zero", credit_avail[23:16], 0);

        // Saturation and flag clear.
        cfg_enable = 4'h0;
        req_valid  = 4'h0;
        gnt_accept = 1'b0;
        do_load(16'h1111, 32'h0000_FA00);
        check("s1_loaded", credit_avail[15:8], 250);
        credit_ret_valid = 1'b1;
        credit_ret_stack = 2'd1;
        credit_ret_count = 4'd15;
        tick();
        credit_ret_valid = 1'b0;
        check("sat_value", credit_avail[15:8], 255);
        check("sat_flag", credit_ovf_err, 1);
        do_load(16'h1111, 32'h0000_FA00);
        check("flag_cleared", credit_ovf_err, 0);

        // Simultaneous consume and return on stack 0.
        cfg_enable = 4'b0001;
        req_valid  = 4'b0001;
        do_load(16'h0004, 32'h0000_0005);
        wait_grant("s0");
        check("s0_id", gnt_stack_id, 0);
        gnt_accept       = 1'b1;
        credit_ret_valid = 1'b1;
        credit_ret_stack = 2'd0;
        credit_ret_count = 4'd4;
        tick();
        gnt_accept       = 1'b0;
        credit_ret_valid = 1'b0;
        check("consume_plus_return", credit_avail[7:0], 8);

        // Request withdrawn mid-grant.
        cfg_enable = 4'b1000;
        req_valid  = 4'b1000;
        do_load(16'h1000, 32'h0500_0000);
        wait_grant("s3");
        check("s3_id", gnt_stack_id, 3);
        req_valid = 4'b0000;
        tick();
        check("drop_gnt_valid", gnt_valid, 0);
        check("drop_credit", credit_avail[31:24], 5);
        check("drop_state", sched_state, 0);

        // Asynchronous reset while granting.
        req_valid = 4'b1000;
        wait_grant("s3_again");
        rst = 1'b1;
        #1;
        check("arst_gnt", gnt, 0);
        check("arst_gnt_valid", gnt_valid, 0);
        check("arst_stack_id", gnt_stack_id, 0);
        check("arst_credit", credit_avail, 0);
        check("arst_ovf", credit_ovf_err, 0);
        check("arst_state", sched_state, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        // Random traffic.
        cfg_enable = 4'hf;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 0 || $urandom_range(0, 59) == 0) begin
                cfg_load   = 1'b1;
                cfg_weight = WW*NS'($urandom);
                for (int i = 0; i < NS; i++) begin
                    cfg_init_credit[i*CW +: CW] = ($urandom_range(0, 7) == 0) ?
                        CW'($urandom_range(240, 255)) : CW'($urandom_range(0, 10));
                end
            end else begin
                cfg_load = 1'b0;
            end
            if ($urandom_range(0, 31) == 0) cfg_enable = NS'($urandom);
            req_valid        = NS'($urandom | $urandom);
            gnt_accept       = ($urandom_range(0, 3) != 0);
            credit_ret_valid = ($urandom_range(0, 3) == 0);
            credit_ret_stack = 2'($urandom);
            credit_ret_count = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            tick();
        end
        cfg_load = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ucie_stack_wrr_scheduler.md
UCIE_STACK_WRR_SCHEDULER -- requirements
Module: ucie_stack_wrr_scheduler

Interface
REQ-001 SHALL have parameter NUM_STACKS, default 4, number of protocol stacks scheduled.
REQ-002 SHALL have parameter CREDIT_W, default 8, width of each per-stack credit counter.
REQ-003 SHALL have parameter WEIGHT_W, default 4, width of each per-stack weight.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- cfg_enable  in  NUM_STACKS  per-stack enable.
- cfg_weight  in  WEIGHT_W x NUM_STACKS  flits per round per stack.
- cfg_init_credit  in  CREDIT_W x NUM_STACKS  credit load value.
- cfg_load  in  1  pulse that loads credits and budgets.
- req_valid  in  NUM_STACKS  stack has a flit pending.
- gnt  out  NUM_STACKS  one-hot grant.
- gnt_valid  out  1  a grant is asserted.
- gnt_stack_id  out  clog2(NUM_STACKS)  granted stack index.
- gnt_accept  in  1  downstream consumed the granted flit.
- credit_ret_valid  in  1  remote credit return.
- credit_ret_stack  in  clog2(NUM_STACKS)  return target stack.
- credit_ret_count  in  4  credits returned.
- credit_avail  out  CREDIT_W x NUM_STACKS  current credits.
- credit_ovf_err  out  1  sticky saturation flag.
- sched_state  out  2  FSM state.

Function
REQ-006 A stack SHALL be eligible when cfg_enable, req_valid and credit_avail>0 are all true; it is selectable when it is eligible and its budget is >0.
REQ-007 FSM states SHALL be IDLE=0, GRANT=1 and REFILL=2; sched_state SHALL output the current state.
REQ-008 IDLE: with at least one selectable stack, the FSM SHALL register the round-robin winner, searching from last_granted+1 modulo NUM_STACKS, and enter GRANT; gnt SHALL assert the cycle after req_valid is seen.
REQ-009 IDLE: if at least one stack is eligible but none is selectable, the FSM SHALL enter REFILL.
REQ-010 REFILL SHALL last exactly 1 cycle, reload every budget from its weight (weight 0 treated as 1), then return to IDLE.
REQ-011 GRANT: gnt, gnt_stack_id and gnt_valid SHALL stay stable until gnt_accept or until the granted stack becomes ineligible.
REQ-012 On gnt_accept in GRANT: the granted stack's credit and budget SHALL each decrement by 1, and last_granted SHALL update to the granted stack.
REQ-013 After that accept: if the stack is still eligible (using the post-decrement values) and its budget is >0, GRANT SHALL hold the same stack with no bubble; otherwise the FSM SHALL go to IDLE.
REQ-014 If the granted stack becomes ineligible without an accept, the grant SHALL drop the next cycle and the FSM SHALL go to IDLE; no credit is consumed.
REQ-015 gnt_accept outside GRANT SHALL be ignored.
REQ-016 A credit return SHALL add credit_ret_count to the target stack; the result SHALL saturate at 2^CREDIT_W-1, and saturation SHALL set credit_ovf_err.
REQ-017 When a return and a consume hit the same stack in the same cycle, the new credit SHALL be credit-1+count, with saturation applied to that result.
REQ-018 cfg_load SHALL take priority over everything else: credits load from cfg_init_credit, budgets reload, credit_ovf_err clears and the FSM goes to IDLE.
REQ-019 An accept or a credit return in the same cycle as cfg_load SHALL be discarded.
REQ-020 Disabling a stack SHALL NOT alter its credit.

Reset
REQ-021 On rst: gnt=0, gnt_valid=0, gnt_stack_id=0, credit_avail=0 for all stacks, budgets=0, last_granted=NUM_STACKS-1, credit_ovf_err=0, FSM=IDLE.
REQ-022 Reset asserted mid-GRANT SHALL drop gnt immediately, asynchronously.
REQ-023 After reset, no grant SHALL issue before a cfg_load or a credit return supplies credit.

Structure
REQ-024 The sched_state_t enum and the default NUM_STACKS/CREDIT_W/WEIGHT_W constants SHALL reside in ucie_pkg.
REQ-025 The rotating first-set search SHALL be one sub-module, ucie_rr_pick (request vector + start index -> index + found).

Verification
REQ-026 Weights {2,1,1,1}, credits 8, all requesting continuously, gnt_accept tied high -> grant order 0,0,1,2,3, then REFILL, then 0,0,1...
REQ-027 Stack 2 alone, credit 3, accept always high -> exactly 3 grants, then stack 2 is not granted; credit_avail[2]=0.
REQ-028 credit_avail[1]=250 with returns of 15 -> value 255, credit_ovf_err=1; a following cfg_load clears the flag.
REQ-029 Accept on stack 0 in the same cycle as a return of 4 to stack 0, credit 5 -> credit 8.
REQ-030 req_valid[3] drops mid-GRANT with no accept -> gnt drops the next cycle, credit unchanged, FSM IDLE.
REQ-031 rst pulse during GRANT -> gnt=0 asynchronously; all outputs at their reset values.
